// File: rtl/ksa_param.sv
// Kogge-Stone parallel-prefix adder with registered sum/cout/out_valid.
// Define KSA_PARAM_INPUT_REG_EN to register a/b/cin/in_valid ahead of the tree (2-cycle latency).
module ksa_param #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         out_valid
);

  localparam int STAGES = (N > 1) ? $clog2(N) : 0;

  logic [N-1:0] t_a_s;
  logic [N-1:0] t_b_s;
  logic         t_cin_s;
  logic         t_valid_s;

`ifdef KSA_PARAM_INPUT_REG_EN
  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  logic         cin_r;
  logic         valid_r;

  // Input isolation registers feeding the prefix tree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      cin_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      a_r     <= a;
      b_r     <= b;
      cin_r   <= cin;
      valid_r <= in_valid;
    end
  end

  assign t_a_s     = a_r;
  assign t_b_s     = b_r;
  assign t_cin_s   = cin_r;
  assign t_valid_s = valid_r;
`else
  assign t_a_s     = a;
  assign t_b_s     = b;
  assign t_cin_s   = cin;
  assign t_valid_s = in_valid;
`endif

  logic [N-1:0] g_s;
  logic [N-1:0] p_s;
  logic [N-1:0] gt_s [0:STAGES];
  logic [N-1:0] pt_s [0:STAGES];
  logic [N:0]   carry_s;
  logic [N-1:0] sum_s;

  assign g_s = t_a_s & t_b_s;
  assign p_s = t_a_s ^ t_b_s;

  // cin is folded into bit 0's generate so the tree needs no extra carry input.
  for (genvar i = 0; i < N; i++) begin : g_init
    if (i == 0) begin : g_b0
      assign gt_s[0][i] = g_s[i] | (p_s[i] & t_cin_s);
    end else begin : g_bn
      assign gt_s[0][i] = g_s[i];
    end
    assign pt_s[0][i] = p_s[i];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int D = 2 ** k;
    for (genvar i = 0; i < N; i++) begin : g_cell
      if (i >= D) begin : g_black
        assign gt_s[k+1][i] = gt_s[k][i] | (pt_s[k][i] & gt_s[k][i-D]);
        assign pt_s[k+1][i] = pt_s[k][i] & pt_s[k][i-D];
      end else begin : g_pass
        assign gt_s[k+1][i] = gt_s[k][i];
        assign pt_s[k+1][i] = pt_s[k][i];
      end
    end
  end

  assign carry_s[0]   = t_cin_s;
  assign carry_s[N:1] = gt_s[STAGES];
  assign sum_s        = p_s ^ carry_s[N-1:0];

  // Result registers; data holds when no valid operand arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= t_valid_s;
      if (t_valid_s) begin
        sum  <= sum_s;
        cout <= carry_s[N];
      end
    end
  end

endmodule

// File: tb/tb_ksa_param.sv
// Self-checking bench for ksa_param: N=8 directed table plus a shared random/hold/reset run on N=1,5,8,16,32.
module tb_ksa_param;

`ifdef KSA_PARAM_INPUT_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic iv    = 1'b0;

  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic [0:0]  a1 = '0, b1 = '0, s1;
  logic [4:0]  a5 = '0, b5 = '0, s5;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic ci8 = 1'b0, ci1 = 1'b0, ci5 = 1'b0, ci16 = 1'b0, ci32 = 1'b0;
  logic co8, co1, co5, co16, co32;
  logic ov8, ov1, ov5, ov16, ov32;

  ksa_param #(.N(8))  u8  (.clk(clk), .rst_n(rst_n), .in_valid(iv), .a(a8),  .b(b8),  .cin(ci8),  .sum(s8),  .cout(co8),  .out_valid(ov8));
  ksa_param #(.N(1))  u1  (.clk(clk), .rst_n(rst_n), .in_valid(iv), .a(a1),  .b(b1),  .cin(ci1),  .sum(s1),  .cout(co1),  .out_valid(ov1));
  ksa_param #(.N(5))  u5  (.clk(clk), .rst_n(rst_n), .in_valid(iv), .a(a5),  .b(b5),  .cin(ci5),  .sum(s5),  .cout(co5),  .out_valid(ov5));
  ksa_param #(.N(16)) u16 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .a(a16), .b(b16), .cin(ci16), .sum(s16), .cout(co16), .out_valid(ov16));
  ksa_param #(.N(32)) u32 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .a(a32), .b(b32), .cin(ci32), .sum(s32), .cout(co32), .out_valid(ov32));

  typedef struct packed {
    logic        v;
    logic [8:0]  r8;
    logic [1:0]  r1;
    logic [5:0]  r5;
    logic [16:0] r16;
    logic [32:0] r32;
  } ent_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  ent_t pipe [0:1];
  ent_t mdl;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic rnd();
    a8 = 8'($urandom);   b8 = 8'($urandom);   ci8 = 1'($urandom_range(1, 0));
    a1 = 1'($urandom);   b1 = 1'($urandom);   ci1 = 1'($urandom_range(1, 0));
    a5 = 5'($urandom);   b5 = 5'($urandom);   ci5 = 1'($urandom_range(1, 0));
    a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom_range(1, 0));
    a32 = $urandom;      b32 = $urandom;      ci32 = 1'($urandom_range(1, 0));
  endtask

  task automatic ones();
    a8 = '1;  b8 = '1;  ci8 = 1'b1;
    a1 = '1;  b1 = '1;  ci1 = 1'b1;
    a5 = '1;  b5 = '1;  ci5 = 1'b1;
    a16 = '1; b16 = '1; ci16 = 1'b1;
    a32 = '1; b32 = '1; ci32 = 1'b1;
  endtask

  // One clock: apply control at negedge, advance the reference pipeline, compare every instance.
  task automatic cycle(input logic iv_i, input logic rst_i);
    ent_t e;
    @(negedge clk);
    rst_n = rst_i;
    iv    = iv_i;
    e.v   = iv_i;
    e.r8  = {1'b0, a8}  + {1'b0, b8}  + 9'(ci8);
    e.r1  = {1'b0, a1}  + {1'b0, b1}  + 2'(ci1);
    e.r5  = {1'b0, a5}  + {1'b0, b5}  + 6'(ci5);
    e.r16 = {1'b0, a16} + {1'b0, b16} + 17'(ci16);
    e.r32 = {1'b0, a32} + {1'b0, b32} + 33'(ci32);
    @(posedge clk);
    #1;
    if (!rst_i) begin
      pipe[0] = '0;
      pipe[1] = '0;
      mdl     = '0;
    end else begin
      for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = e;
      if (pipe[L-1].v) mdl = pipe[L-1];
      else mdl.v = 1'b0;
    end
    chk("ov8",  64'(ov8),  64'(mdl.v));  chk("res8",  64'({co8, s8}),   64'(mdl.r8));
    chk("ov1",  64'(ov1),  64'(mdl.v));  chk("res1",  64'({co1, s1}),   64'(mdl.r1));
    chk("ov5",  64'(ov5),  64'(mdl.v));  chk("res5",  64'({co5, s5}),   64'(mdl.r5));
    chk("ov16", 64'(ov16), 64'(mdl.v));  chk("res16", 64'({co16, s16}), 64'(mdl.r16));
    chk("ov32", 64'(ov32), 64'(mdl.v));  chk("res32", 64'({co32, s32}), 64'(mdl.r32));
  endtask

  vec_t vecs [7];

  initial begin
    pipe[0] = '0;
    pipe[1] = '0;
    mdl     = '0;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    // Reset held two cycles with live random operands.
    rnd(); cycle(1'b1, 1'b0);
    rnd(); cycle(1'b1, 1'b0);
    chk("rst_sum", 64'(s8), 64'h00);
    chk("rst_cout", 64'(co8), 64'h0);
    chk("rst_ov", 64'(ov8), 64'h0);

    // Directed table on the 8-bit instance.
    for (int v = 0; v < 7; v++) begin
      a8 = vecs[v].a; b8 = vecs[v].b; ci8 = vecs[v].cin;
      for (int k = 0; k < L; k++) cycle(1'b1, 1'b1);
      chk("vec_sum", 64'(s8), 64'(vecs[v].es));
      chk("vec_cout", 64'(co8), 64'(vecs[v].ec));
      chk("vec_ov", 64'(ov8), 64'h1);
    end

    // Latency: single valid pulse after a drained pipe.
    for (int k = 0; k < L + 1; k++) cycle(1'b0, 1'b1);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
    cycle(1'b1, 1'b1);
    for (int k = 1; k <= L; k++) begin
      if (k > 1) cycle(1'b0, 1'b1);
      chk("lat_ov", 64'(ov8), 64'(k == L));
    end
    chk("lat_sum", 64'(s8), 64'h46);

    // Back-to-back random stream, starting with all-ones plus carry-in.
    for (int i = 0; i < 256; i++) begin
      if (i < 2) ones();
      else rnd();
      cycle(1'b1, 1'b1);
    end

    // Drop in_valid: results hold, out_valid falls once the pipe drains.
    for (int k = 0; k < L + 2; k++) begin
      rnd();
      cycle(1'b0, 1'b1);
    end
    chk("hold_ov", 64'(ov8), 64'h0);

    // Mid-stream reset discards everything in flight.
    rnd(); cycle(1'b1, 1'b1);
    rnd(); cycle(1'b1, 1'b1);
    rnd(); cycle(1'b1, 1'b0);
    chk("mrst_sum", 64'(s8), 64'h00);
    chk("mrst_cout", 64'(co8), 64'h0);
    chk("mrst_ov", 64'(ov8), 64'h0);
    for (int k = 0; k < 4; k++) begin
      rnd();
      cycle(1'b1, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
